barrel_shift_pipe: RTL

//  Pipelined, flow-controlled counterpart of the combinational barrel_shift datapath.

---
 rtl/barrel_shift_pipe.sv | 111 +++++++++++
 1 files changed

// File: rtl/barrel_shift_pipe.sv
// Pipelined, valid/ready flow-controlled barrel shifter: stage k applies a 2^k shift when shift_num[k]=1.
// Optional BSHIFT_PIPE_ERR_EN adds out_err, flagging results of pass-through ops 5..7.
module barrel_shift_pipe #(
  parameter int unsigned N     = 8,
  parameter int unsigned LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     data_in,
  input  logic [LOG2N-1:0] shift_num,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     data_out
`ifdef BSHIFT_PIPE_ERR_EN
  ,
  output logic             out_err
`endif
);

  typedef enum logic [2:0] {
    OP_LSR = 3'd0,
    OP_ASR = 3'd1,
    OP_LSL = 3'd2,
    OP_ROR = 3'd3,
    OP_ROL = 3'd4
  } op_e;

  logic [LOG2N-1:0]            vld_q, ld, src_vld;
  logic [LOG2N-1:0][N-1:0]     data_q, data_d;
  logic [LOG2N-1:0][2:0]       op_q, op_d;
  logic [LOG2N-1:0][LOG2N-1:0] sh_q, sh_d;
  logic                        room;
  logic                        unused_bits;

  function automatic logic [N-1:0] step(input logic [N-1:0] d, input logic [2:0] o,
                                        input int unsigned amt);
    logic [N-1:0] r;
    case (o)
      OP_LSR:  r = d >> amt;
      OP_ASR:  r = $signed(d) >>> amt;
      OP_LSL:  r = d << amt;
      OP_ROR:  r = (d >> amt) | (d << (N - amt));
      OP_ROL:  r = (d << amt) | (d >> (N - amt));
      default: r = d;
    endcase
    return r;
  endfunction

  // A stage may load if any stage at or after it is empty, or the output drains;
  // this collapses bubbles without a dedicated advance vector.
  always_comb begin
    room = out_ready;
    ld   = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      room              = room || !vld_q[LOG2N-1-i];
      ld[LOG2N-1-i]     = room;
    end
  end

  always_comb begin
    src_vld    = '0;
    data_d     = '0;
    op_d       = '0;
    sh_d       = '0;
    src_vld[0] = in_valid;
    op_d[0]    = op;
    sh_d[0]    = shift_num;
    data_d[0]  = shift_num[0] ? step(data_in, op, 1) : data_in;
    for (int unsigned k = 1; k < LOG2N; k++) begin
      src_vld[k] = vld_q[k-1];
      op_d[k]    = op_q[k-1];
      sh_d[k]    = sh_q[k-1];
      data_d[k]  = sh_q[k-1][k] ? step(data_q[k-1], op_q[k-1], 32'd1 << k) : data_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
      op_q   <= '0;
      sh_q   <= '0;
    end else begin
      for (int unsigned k = 0; k < LOG2N; k++) begin
        if (ld[k]) begin
          vld_q[k] <= src_vld[k];
          if (src_vld[k]) begin
            data_q[k] <= data_d[k];
            op_q[k]   <= op_d[k];
            sh_q[k]   <= sh_d[k];
          end
        end
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_q[LOG2N-1];
  assign data_out  = data_q[LOG2N-1];

`ifdef BSHIFT_PIPE_ERR_EN
  assign out_err = vld_q[LOG2N-1] && (op_q[LOG2N-1] > 3'd4);
`endif

  // Consumed shift bits and the last stage's op are carried but not all read.
  assign unused_bits = ^{sh_q, op_q[LOG2N-1]};

endmodule
